vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Consumer end of the resolution parameter memory.
- Issues a request to the resolution memory and captures the returned timing set (display, front porch, retrace, back porch for H and V).
- Runs the horizontal and vertical pixel counters and drives hsync/vsync, display-enable and pixel coordinates to the pixel pipeline.
- Resolution changes are deferred to frame boundaries, so no partial frame is ever emitted.

Parameters:
- HSYNC_ACTIVE, 1, level driven on hsync_o during horizontal retrace.
- VSYNC_ACTIVE, 1, level driven on vsync_o during vertical retrace.

Ports:
- clk_i  in  1  pixel clock
- arstn_i  in  1  asynchronous active-low reset
- start_i  in  1  single-cycle pulse: (re)load timings for the currently selected resolution
- req_o  out  1  request to the resolution memory; one-cycle pulse
- valid_i  in  1  resolution memory data valid
- hd_i, hf_i, hr_i, hb_i  in  VGA_MAX_H_WIDTH  horizontal display / front porch / retrace / back porch
- vd_i, vf_i, vr_i, vb_i  in  VGA_MAX_V_WIDTH  vertical equivalents
- hsync_o  out  1  horizontal sync
- vsync_o  out  1  vertical sync
- de_o  out  1  active display area
- x_o  out  VGA_MAX_H_WIDTH  pixel column; 0 when de_o=0
- y_o  out  VGA_MAX_V_WIDTH  pixel row; 0 when de_o=0
- frame_start_o  out  1  pulse on pixel (0,0)
- err_o  out  1  pulse: rejected timing set
- running_o  out  1  state==RUN

Behaviour:
- Reset values:
  - state IDLE, counters 0, pending 0.
  - req_o, de_o, frame_start_o, err_o, running_o all 0; x_o and y_o 0.
  - hsync_o = ~HSYNC_ACTIVE, vsync_o = ~VSYNC_ACTIVE.
- FSM states: IDLE, REQ, WAIT, RUN.
  - IDLE: start_i -> REQ.
  - REQ: req_o=1 for exactly one cycle -> WAIT.
  - WAIT: hold until valid_i=1, then sample all eight timing inputs into shadow registers the same cycle.
    - If any of hd_i, hr_i, vd_i, vr_i is 0: err_o pulses one cycle and state returns to IDLE.
    - Otherwise -> RUN with h_cnt = v_cnt = 0.
  - RUN: counters advance every cycle.
    - start_i sets pending.
    - When h_cnt=HT-1 and v_cnt=VT-1 with pending=1: clear pending and go to REQ.
- Totals:
  - HT = hd+hf+hr+hb, computed in H_CNT_W = VGA_MAX_H_WIDTH+2 bits; VT uses V_CNT_W likewise.
  - No overflow is possible.
- Counters:
  - h_cnt wraps from HT-1 to 0.
  - v_cnt increments on the h wrap and wraps from VT-1 to 0.
- Decode order is display, front porch, retrace, back porch:
  - de = (h<hd)&(v<vd)
  - hsync active for hd+hf <= h < hd+hf+hr
  - vsync active for vd+vf <= v < vd+vf+vr; vsync changes on the h wrap.
- Timing alignment:
  - All outputs are registered.
  - Output values in cycle n reflect counter values held in cycle n-1, i.e. one cycle latency from counter to pins.
  - frame_start_o is high in the same cycle as de_o for (0,0).
- Outside RUN: outputs are held at their reset/inactive values, one cycle after leaving RUN.
- start_i handling:
  - A start_i during REQ or WAIT is ignored.
  - A start_i coincident with the frame-end cycle is taken (pending evaluated including start_i).
- valid_i is ignored outside WAIT.
- Zero porch (hf, hb, vf, vb = 0) is legal.
- Reset mid-frame: immediate return to reset values. The shadow registers are not reset and are reloaded before use.

Optional Feature:
- Macro VGA_TIMING_GEN_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt_o [15:0], reset 0.
  - Increments on each frame_start_o and wraps 0xFFFF -> 0.
  - Cleared on entry to WAIT.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- vga_pkg holds:
  - VGA_MAX_H_WIDTH, VGA_MAX_V_WIDTH, and new constants H_CNT_W and V_CNT_W.
  - Typedef vga_timing_t, a packed struct holding the 8 fields.
  - Enum vga_tgen_state_e for the four states.
- One natural sub-module, vga_axis_cnt, instantiated twice (H and V):
  - Inputs: the d/f/r/b fields, an advance enable and a clear.
  - Outputs: count, wrap, active-display and sync-active flags.

Test Plan:
- Reset, then start_i; valid_i returns 800x600 (hd800 hf40 hr128 hb88, vd600 vf1 vr4 vb23) two cycles after req_o.
  - Required: req_o is a single pulse.
  - HT=1056, VT=628.
  - hsync active for h 840..967, de for h 0..799.
  - vsync active for rows 601..604.
  - frame_start_o every 663168 cycles.
- Sample x_o/y_o at the last visible pixel -> x=799, y=599, de_o=1; the next cycle gives de_o=0, x_o=0.
- start_i mid-frame at row 300:
  - No req_o until after h=1055, v=627.
  - Then req_o pulses, outputs go inactive, and a new timing set (hd640 hf16 hr96 hb48, vd480 vf10 vr2 vb33) gives HT=800, VT=525.
- Timing set with vr=0 -> err_o one-cycle pulse, state IDLE, hsync_o=~HSYNC_ACTIVE, de_o=0.
- Zero porches (hf=hb=0, hd=4, hr=2; vd=2, vr=1, vf=vb=0):
  - hsync covers h 4..5, HT=6.
  - vsync covers row 2, VT=3.
- arstn_i low mid-line: all outputs return to reset values asynchronously; the first start_i after release behaves as in scenario 1.
- With VGA_TIMING_GEN_FRAME_CNT_EN defined: frame_cnt_o=3 after the third frame_start_o, and 0 after the next start_i reload.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared constants, timing-set record and FSM state encoding
//               for the VGA timing generator.
//                 VGA_MAX_H_WIDTH / VGA_MAX_V_WIDTH : width of one timing field
//                 H_CNT_W / V_CNT_W                 : counter width, wide enough
//                                                     to hold d+f+r+b
//                 vga_timing_t                      : the eight timing fields
//                 vga_tgen_state_e                  : IDLE / REQ / WAIT / RUN
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

   localparam int VGA_MAX_H_WIDTH = 12;
   localparam int VGA_MAX_V_WIDTH = 11;

   // Two extra bits: the sum of four W-bit fields never exceeds 4*(2^W-1).
   localparam int H_CNT_W = VGA_MAX_H_WIDTH + 2;
   localparam int V_CNT_W = VGA_MAX_V_WIDTH + 2;

   typedef struct packed {
      logic [VGA_MAX_H_WIDTH-1:0] hd;
      logic [VGA_MAX_H_WIDTH-1:0] hf;
      logic [VGA_MAX_H_WIDTH-1:0] hr;
      logic [VGA_MAX_H_WIDTH-1:0] hb;
      logic [VGA_MAX_V_WIDTH-1:0] vd;
      logic [VGA_MAX_V_WIDTH-1:0] vf;
      logic [VGA_MAX_V_WIDTH-1:0] vr;
      logic [VGA_MAX_V_WIDTH-1:0] vb;
   } vga_timing_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RUN  = 2'd3
   } vga_tgen_state_e;

   // A set without display area or without a retrace pulse cannot produce a
   // usable raster; porches may legitimately be zero.
   function automatic logic timing_invalid(input vga_timing_t t);
      return (t.hd == '0) || (t.hr == '0) || (t.vd == '0) || (t.vr == '0);
   endfunction

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_axis_cnt.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_cnt
// Description : One raster axis (horizontal or vertical). Counts 0..T-1 with
//               T = d+f+r+b and decodes the display and sync windows
//               (order: display, front porch, retrace, back porch).
// Ports       : clk_i, arstn_i      - clock, async active-low reset
//               i_d/i_f/i_r/i_b     - display / front / retrace / back lengths
//               i_en                - advance the count this cycle
//               i_clr               - force the count to 0 (wins over i_en)
//               o_cnt               - current count
//               o_wrap              - count is at T-1
//               o_act               - count inside the display window
//               o_sync              - count inside the retrace window
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_cnt #(
   parameter int FIELD_W = 12,
   parameter int CNT_W   = 14
) (
   input  logic               clk_i,
   input  logic               arstn_i,
   input  logic [FIELD_W-1:0] i_d,
   input  logic [FIELD_W-1:0] i_f,
   input  logic [FIELD_W-1:0] i_r,
   input  logic [FIELD_W-1:0] i_b,
   input  logic               i_en,
   input  logic               i_clr,
   output logic [CNT_W-1:0]   o_cnt,
   output logic               o_wrap,
   output logic               o_act,
   output logic               o_sync
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_d;
   logic [CNT_W-1:0] w_sync_lo;
   logic [CNT_W-1:0] w_sync_hi;
   logic [CNT_W-1:0] w_total;

   assign w_d       = CNT_W'(i_d);
   assign w_sync_lo = w_d + CNT_W'(i_f);
   assign w_sync_hi = w_sync_lo + CNT_W'(i_r);
   assign w_total   = w_sync_hi + CNT_W'(i_b);

   assign o_wrap = (r_cnt == (w_total - CNT_W'(1)));
   assign o_act  = (r_cnt < w_d);
   assign o_sync = (r_cnt >= w_sync_lo) && (r_cnt < w_sync_hi);
   assign o_cnt  = r_cnt;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= o_wrap ? '0 : r_cnt + CNT_W'(1);
      end
   end

endmodule : vga_axis_cnt
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Fetches a timing set from the resolution memory, then runs the
//               H/V raster counters and drives sync, display enable and pixel
//               coordinates. A new start_i while running is deferred to the
//               end of the current frame so no partial frame is emitted.
//               Optional build macro VGA_TIMING_GEN_FRAME_CNT_EN adds a 16-bit
//               frame counter output (frame_cnt_o).
// Ports       : clk_i, arstn_i     - pixel clock, async active-low reset
//               start_i            - (re)load timings for current resolution
//               req_o / valid_i    - request / data-valid to resolution memory
//               hd_i..hb_i         - horizontal display/front/retrace/back
//               vd_i..vb_i         - vertical display/front/retrace/back
//               hsync_o, vsync_o   - sync outputs (polarity by parameter)
//               de_o, x_o, y_o     - display enable and pixel coordinates
//               frame_start_o      - pulse on pixel (0,0)
//               err_o              - pulse when a timing set is rejected
//               running_o          - raster is running
//               frame_cnt_o        - frames started since last load (option)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter logic HSYNC_ACTIVE = 1'b1,
   parameter logic VSYNC_ACTIVE = 1'b1
) (
   input  logic                       clk_i,
   input  logic                       arstn_i,
   input  logic                       start_i,
   output logic                       req_o,
   input  logic                       valid_i,
   input  logic [VGA_MAX_H_WIDTH-1:0] hd_i,
   input  logic [VGA_MAX_H_WIDTH-1:0] hf_i,
   input  logic [VGA_MAX_H_WIDTH-1:0] hr_i,
   input  logic [VGA_MAX_H_WIDTH-1:0] hb_i,
   input  logic [VGA_MAX_V_WIDTH-1:0] vd_i,
   input  logic [VGA_MAX_V_WIDTH-1:0] vf_i,
   input  logic [VGA_MAX_V_WIDTH-1:0] vr_i,
   input  logic [VGA_MAX_V_WIDTH-1:0] vb_i,
   output logic                       hsync_o,
   output logic                       vsync_o,
   output logic                       de_o,
   output logic [VGA_MAX_H_WIDTH-1:0] x_o,
   output logic [VGA_MAX_V_WIDTH-1:0] y_o,
   output logic                       frame_start_o,
   output logic                       err_o,
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
   output logic [15:0]                frame_cnt_o,
`endif
   output logic                       running_o
);

   vga_tgen_state_e            r_state;
   vga_timing_t                r_tim;
   logic                       r_pending;
   logic                       r_req;
   logic                       r_err;
   logic                       r_running;
   logic                       r_hsync;
   logic                       r_vsync;
   logic                       r_de;
   logic                       r_fs;
   logic [VGA_MAX_H_WIDTH-1:0] r_x;
   logic [VGA_MAX_V_WIDTH-1:0] r_y;

   vga_timing_t                w_in;
   logic                       w_run;
   logic                       w_in_bad;
   logic                       w_load;
   logic                       w_frame_end;
   logic                       w_reload;
   logic                       w_running_nxt;
   logic                       w_at_origin;
   logic                       w_de;

   logic [H_CNT_W-1:0]         w_h_cnt;
   logic                       w_h_wrap;
   logic                       w_h_act;
   logic                       w_h_sync;
   logic [V_CNT_W-1:0]         w_v_cnt;
   logic                       w_v_wrap;
   logic                       w_v_act;
   logic                       w_v_sync;

   assign w_in = '{hd: hd_i, hf: hf_i, hr: hr_i, hb: hb_i,
                   vd: vd_i, vf: vf_i, vr: vr_i, vb: vb_i};

   assign w_run       = (r_state == ST_RUN);
   assign w_in_bad    = timing_invalid(w_in);
   assign w_load      = (r_state == ST_WAIT) && valid_i && !w_in_bad;
   assign w_frame_end = w_run && w_h_wrap && w_v_wrap;
   // A start_i landing exactly on the last pixel still triggers the reload.
   assign w_reload    = w_frame_end && (r_pending || start_i);
   assign w_running_nxt = w_load || (w_run && !w_reload);
   // Compare full counter width so the upper counter bits are not dangling.
   assign w_at_origin = (w_h_cnt == '0) && (w_v_cnt == '0);
   assign w_de        = w_h_act && w_v_act;

   // Shadow copy of the timing set. Deliberately not reset: it is always
   // reloaded in WAIT before the counters are allowed to run.
   always_ff @(posedge clk_i) begin
      if ((r_state == ST_WAIT) && valid_i) begin
         r_tim <= w_in;
      end
   end

   vga_axis_cnt #(
      .FIELD_W (VGA_MAX_H_WIDTH),
      .CNT_W   (H_CNT_W)
   ) u_h_cnt (
      .clk_i   (clk_i),
      .arstn_i (arstn_i),
      .i_d     (r_tim.hd),
      .i_f     (r_tim.hf),
      .i_r     (r_tim.hr),
      .i_b     (r_tim.hb),
      .i_en    (w_run),
      .i_clr   (w_load),
      .o_cnt   (w_h_cnt),
      .o_wrap  (w_h_wrap),
      .o_act   (w_h_act),
      .o_sync  (w_h_sync)
   );

   // Vertical axis steps only on the horizontal wrap, so vsync changes there.
   vga_axis_cnt #(
      .FIELD_W (VGA_MAX_V_WIDTH),
      .CNT_W   (V_CNT_W)
   ) u_v_cnt (
      .clk_i   (clk_i),
      .arstn_i (arstn_i),
      .i_d     (r_tim.vd),
      .i_f     (r_tim.vf),
      .i_r     (r_tim.vr),
      .i_b     (r_tim.vb),
      .i_en    (w_run && w_h_wrap),
      .i_clr   (w_load),
      .o_cnt   (w_v_cnt),
      .o_wrap  (w_v_wrap),
      .o_act   (w_v_act),
      .o_sync  (w_v_sync)
   );

   // Control FSM plus registered pixel outputs. Outputs are decoded from the
   // counter values of the current cycle, giving one cycle of latency.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_state   <= ST_IDLE;
         r_pending <= 1'b0;
         r_req     <= 1'b0;
         r_err     <= 1'b0;
         r_running <= 1'b0;
         r_hsync   <= ~HSYNC_ACTIVE;
         r_vsync   <= ~VSYNC_ACTIVE;
         r_de      <= 1'b0;
         r_fs      <= 1'b0;
         r_x       <= '0;
         r_y       <= '0;
      end else begin
         r_req     <= 1'b0;
         r_err     <= 1'b0;
         r_running <= w_running_nxt;

         case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  r_state <= ST_REQ;
                  r_req   <= 1'b1;
               end
            end
            ST_REQ: begin
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (valid_i) begin
                  if (w_in_bad) begin
                     r_state <= ST_IDLE;
                     r_err   <= 1'b1;
                  end else begin
                     r_state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (w_reload) begin
                  r_state   <= ST_REQ;
                  r_req     <= 1'b1;
                  r_pending <= 1'b0;
               end else if (start_i) begin
                  r_pending <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase

         if (w_run) begin
            r_de    <= w_de;
            r_hsync <= w_h_sync ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
            r_vsync <= w_v_sync ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
            r_fs    <= w_at_origin;
            r_x     <= w_de ? w_h_cnt[VGA_MAX_H_WIDTH-1:0] : '0;
            r_y     <= w_de ? w_v_cnt[VGA_MAX_V_WIDTH-1:0] : '0;
         end else begin
            r_de    <= 1'b0;
            r_hsync <= ~HSYNC_ACTIVE;
            r_vsync <= ~VSYNC_ACTIVE;
            r_fs    <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
         end
      end
   end

`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;

   // Steps together with the frame_start_o register; REQ always precedes
   // WAIT, so clearing in REQ is clearing on entry to WAIT.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_frame_cnt <= '0;
      end else if (r_state == ST_REQ) begin
         r_frame_cnt <= '0;
      end else if (w_run && w_at_origin) begin
         r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign frame_cnt_o = r_frame_cnt;
`endif

   assign req_o         = r_req;
   assign err_o         = r_err;
   assign running_o     = r_running;
   assign hsync_o       = r_hsync;
   assign vsync_o       = r_vsync;
   assign de_o          = r_de;
   assign frame_start_o = r_fs;
   assign x_o           = r_x;
   assign y_o           = r_y;

endmodule : vga_timing_gen
`default_nettype wire
